// File: rtl/stress_pkg.sv
// Shared types and default constants for the stress threshold comparator.
package stress_pkg;

    // Per-channel state of the hysteresis FSM.
    typedef enum logic {
        CALM     = 1'b0,
        STRESSED = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_HOLD     = 3;

    // Channel index width; a single-channel build still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stress_channel.sv
// One sensor channel: CALM/STRESSED FSM with a consecutive-sample hold counter.
module stress_channel
    import stress_pkg::*;
#(
    parameter int HOLD = DEF_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic high,
    input  logic low,
    output logic stressed,
    output logic flip
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          qual;

    // Decide whether this sample qualifies and whether it completes the hold run.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        qual = 1'b0;
        flip = 1'b0;
        if (state == CALM) begin
            qual = high;
        end else begin
            qual = low;
        end
        flip = en && qual && (cnt == LAST);
    end

    // State and counter update; only a sample addressed to this channel moves it.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= CALM;
            cnt   <= '0;
        end else if (clear) begin
            state <= CALM;
            cnt   <= '0;
        end else if (en) begin
            if (flip) begin
                state <= (state == CALM) ? STRESSED : CALM;
                cnt   <= '0;
            end else if (qual) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign stressed = (state == STRESSED);

endmodule

// File: rtl/stress_threshold_cmp.sv
// Multi-channel stress comparator with entry/exit thresholds and hold filtering.
module stress_threshold_cmp
    import stress_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int HOLD     = DEF_HOLD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          sample_valid,
    input  logic [WIDTH-1:0]              sample,
    input  logic [ch_width(CHANNELS)-1:0] sample_ch,
    input  logic [WIDTH-1:0]              thr_hi,
    input  logic [WIDTH-1:0]              thr_lo,
    output logic [CHANNELS-1:0]           stressed,
    output logic                          any_stressed,
    output logic                          out_valid,
    output logic [ch_width(CHANNELS)-1:0] out_ch,
    output logic                          changed
);

    localparam int CHW = ch_width(CHANNELS);

    logic                in_range;
    logic                accept;
    logic                high;
    logic                low;
    logic [CHANNELS-1:0] flip;

    // Out-of-range channel indices are dropped; clear wins over a simultaneous sample.
    assign in_range = ({1'b0, sample_ch} < (CHW + 1)'(CHANNELS));
    assign accept   = sample_valid && !clear && in_range;
    assign high     = (sample > thr_hi);
    assign low      = (sample < thr_lo);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        stress_channel #(
            .HOLD(HOLD)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .en      (accept && (sample_ch == CHW'(i))),
            .high    (high),
            .low     (low),
            .stressed(stressed[i]),
            .flip    (flip[i])
        );
    end

    assign any_stressed = |stressed;

    // Report each accepted sample one cycle later, flagged if it flipped its channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            changed   <= 1'b0;
        end else begin
            out_valid <= accept;
            changed   <= accept && (|flip);
            if (accept) begin
                out_ch <= sample_ch;
            end
        end
    end

endmodule
